value_deliver_pacer: RTL and testbench

//   clk_a-domain issuer that sits directly upstream of the value_deliver_1cycle CDC stage.

---
 rtl/value_deliver_pacer.sv | 188 ++++++++++++++++++
 tb/tb_value_deliver_pacer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/value_deliver_pacer.sv
// ============================================================================
// Module   : value_deliver_pacer
// Brief    : clk_a-domain FIFO-buffered issuer of paced pulse_in/value_in
//            events feeding the value_deliver_1cycle CDC stage.
//            Optional macro VALUE_DELIVER_PACER_COALESCE_EN: overwrite the
//            youngest entry when full instead of back-pressuring.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module value_deliver_pacer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int GAP   = 6
) (
    input  logic                       clk_a,
    input  logic                       rst_a_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_value,
    output logic                       pulse_in,
    output logic [WIDTH-1:0]           value_in,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       busy
`ifdef VALUE_DELIVER_PACER_COALESCE_EN
    ,
    output logic [7:0]                 overwrite_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = (GAP > 2) ? $clog2(GAP - 1) : 1;

    localparam logic [LW-1:0] c_depth    = LW'(DEPTH);
    localparam logic [CW-1:0] c_gap_load = CW'(GAP - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_pulse;
    logic             w_pulse_nxt;
    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] w_value_nxt;

    logic [LW-1:0]    w_level;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_overwrite;
    logic [PW-1:0]    w_wr_prev;
    logic [AW-1:0]    w_rd_idx;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_young_idx;

    assign w_level     = LW'(r_wr_ptr - r_rd_ptr);
    assign w_full      = (w_level == c_depth);
    assign w_empty     = (w_level == '0);
    assign w_rd_idx    = r_rd_ptr[AW-1:0];
    assign w_wr_idx    = r_wr_ptr[AW-1:0];
    assign w_wr_prev   = r_wr_ptr - PW'(1);
    assign w_young_idx = w_wr_prev[AW-1:0];

    // The head is popped in the same cycle the FSM leaves IDLE.
    assign w_pop = (r_state == ST_IDLE) && !w_empty;

`ifdef VALUE_DELIVER_PACER_COALESCE_EN
    assign in_ready    = 1'b1;
    assign w_push      = in_valid && (!w_full || w_pop);
    assign w_overwrite = in_valid && w_full && !w_pop;
`else
    assign in_ready    = !w_full;
    assign w_push      = in_valid && !w_full;
    assign w_overwrite = 1'b0;
`endif

    always_ff @(posedge clk_a or negedge rst_a_n) begin
        if (!rst_a_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[w_wr_idx] <= in_value;
        end else if (w_overwrite) begin
            r_mem[w_young_idx] <= in_value;
        end
    end

    always_ff @(posedge clk_a or negedge rst_a_n) begin
        if (!rst_a_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

`ifdef VALUE_DELIVER_PACER_COALESCE_EN
    logic [7:0] r_overwrite_cnt;

    always_ff @(posedge clk_a or negedge rst_a_n) begin
        if (!rst_a_n) begin
            r_overwrite_cnt <= 8'h00;
        end else if (w_overwrite && (r_overwrite_cnt != 8'hFF)) begin
            r_overwrite_cnt <= r_overwrite_cnt + 8'h01;
        end
    end

    assign overwrite_cnt = r_overwrite_cnt;
`endif

    always_ff @(posedge clk_a or negedge rst_a_n) begin
        if (!rst_a_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_value <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
            r_value <= w_value_nxt;
        end
    end

    // WAIT spans GAP-2 cycles so pops land exactly GAP cycles apart;
    // with GAP==2 there is nothing to wait for and PULSE returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = 1'b0;
        w_value_nxt = r_value;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pulse_nxt = 1'b1;
                    w_value_nxt = r_mem[w_rd_idx];
                    w_state_nxt = ST_PULSE;
                end
            end
            ST_PULSE: begin
                w_cnt_nxt = c_gap_load;
                if (GAP > 2) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt <= CW'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign pulse_in   = r_pulse;
    assign value_in   = r_value;
    assign fifo_level = w_level;
    assign busy       = !w_empty || (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_value_deliver_pacer.sv
// ============================================================================
// Module   : tb_value_deliver_pacer
// Brief    : Scoreboard bench for value_deliver_pacer (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_value_deliver_pacer;

    localparam int GAP  = 6;
    localparam int DEPTH = 4;
    localparam int GAP2 = 2;

    logic       clk_a   = 1'b0;
    logic       rst_a_n = 1'b0;
    always #5 clk_a = ~clk_a;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_value = 8'h00;
    logic       pulse_in;
    logic [7:0] value_in;
    logic [2:0] fifo_level;
    logic       busy;

    logic       in_valid2 = 1'b0;
    logic       in_ready2;
    logic [7:0] in_value2 = 8'h00;
    logic       pulse_in2;
    logic [7:0] value_in2;
    logic [1:0] fifo_level2;
    logic       busy2;
`ifdef VALUE_DELIVER_PACER_COALESCE_EN
    logic [7:0] overwrite_cnt;
    logic [7:0] overwrite_cnt2;
`endif

    value_deliver_pacer #(.WIDTH(8), .DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk_a(clk_a), .rst_a_n(rst_a_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
        .pulse_in(pulse_in), .value_in(value_in),
        .fifo_level(fifo_level), .busy(busy)
`ifdef VALUE_DELIVER_PACER_COALESCE_EN
        , .overwrite_cnt(overwrite_cnt)
`endif
    );

    value_deliver_pacer #(.WIDTH(8), .DEPTH(2), .GAP(GAP2)) dut2 (
        .clk_a(clk_a), .rst_a_n(rst_a_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_value(in_value2),
        .pulse_in(pulse_in2), .value_in(value_in2),
        .fifo_level(fifo_level2), .busy(busy2)
`ifdef VALUE_DELIVER_PACER_COALESCE_EN
        , .overwrite_cnt(overwrite_cnt2)
`endif
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk_a) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: accepted values must emerge in order, each as an
    // isolated one-cycle strobe at least GAP cycles after the previous one.
    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];
    int         pulse_log[$];
    bit         sb_auto = 1'b1;
    int         last_pulse  = -1000;
    int         last_pulse2 = -1000;

    always @(negedge clk_a) begin
        if (!rst_a_n) begin
            last_pulse = -1000;
        end else begin
            if (sb_auto && in_valid && in_ready) exp_q.push_back(in_value);
            if (pulse_in) begin
                pulse_log.push_back(cyc);
                chk("pulse_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("pulse_value", value_in, exp_q.pop_front());
                chk("pulse_spacing", (cyc - last_pulse) >= GAP, 1);
                last_pulse = cyc;
            end
        end
    end

    always @(negedge clk_a) begin
        if (!rst_a_n) begin
            last_pulse2 = -1000;
        end else begin
            if (in_valid2 && in_ready2) exp2_q.push_back(in_value2);
            if (pulse_in2) begin
                chk("pulse2_expected", exp2_q.size() != 0, 1);
                if (exp2_q.size() != 0) chk("pulse2_value", value_in2, exp2_q.pop_front());
                chk("pulse2_not_adjacent", (cyc - last_pulse2) >= GAP2, 1);
                last_pulse2 = cyc;
            end
        end
    end

    task automatic do_push(input logic [7:0] v);
        @(posedge clk_a);
        #1;
        in_valid = 1'b1;
        in_value = v;
    endtask

    task automatic stop_push();
        @(posedge clk_a);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic at_cycle(input int n);
        do @(negedge clk_a); while (cyc < n);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clk_a);
            n++;
        end
        chk("drain_main_timeout", n < 300, 1);
    endtask

    task automatic wait_idle2();
        int n = 0;
        while ((busy2 || exp2_q.size() != 0) && n < 300) begin
            @(negedge clk_a);
            n++;
        end
        chk("drain_dut2_timeout", n < 300, 1);
    endtask

    initial begin
        int t;
        logic [7:0] v;

        #12;
        chk("rst_pulse_in", pulse_in, 0);
        chk("rst_value_in", value_in, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_in_ready2", in_ready2, 1);
        @(negedge clk_a);
        rst_a_n = 1'b1;
        repeat (2) @(negedge clk_a);

        // Single push: strobe only in t+2, idle again by t+GAP+2.
        pulse_log.delete();
        do_push(8'hA5);
        t = cyc;
        stop_push();
        at_cycle(t + 2);
        chk("t1_pulse_t2", pulse_in, 1);
        chk("t1_value_t2", value_in, 8'hA5);
        chk("t1_busy_t2", busy, 1);
        at_cycle(t + 3);
        chk("t1_pulse_low_t3", pulse_in, 0);
        chk("t1_value_held", value_in, 8'hA5);
        at_cycle(t + GAP + 2);
        chk("t1_busy_done", busy, 0);
        chk("t1_pulse_count", pulse_log.size(), 1);
        if (pulse_log.size() == 1) chk("t1_pulse_cycle", pulse_log[0], t + 2);

        // Four back-to-back handshakes paced exactly GAP apart.
        wait_idle();
        pulse_log.delete();
        do_push(8'h01);
        t = cyc;
        do_push(8'h02);
        do_push(8'h03);
        do_push(8'h04);
        stop_push();
        at_cycle(t + 4 * GAP);
        chk("t2_pulse_count", pulse_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < pulse_log.size()) chk("t2_pulse_cycle", pulse_log[i], t + 2 + GAP * i);
        end

`ifndef VALUE_DELIVER_PACER_COALESCE_EN
        // Backpressure with in_valid held high.
        wait_idle();
        v = 8'h30;
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk_a);
            #1;
            in_valid = 1'b1;
            in_value = v;
            if (k == 0) t = cyc;
            @(negedge clk_a);
            chk("t3_in_ready", in_ready, (k <= 4 || k == 8) ? 1 : 0);
            if (in_ready) v = v + 8'h01;
        end
        stop_push();
        wait_idle();
`endif

        // Async reset while three entries are queued and a strobe is live.
        wait_idle();
        pulse_log.delete();
        do_push(8'h40);
        t = cyc;
        do_push(8'h41);
        do_push(8'h42);
        do_push(8'h43);
        do_push(8'h44);
        stop_push();
        at_cycle(t + 8);
        chk("t4_level_before", fifo_level, 3);
        chk("t4_pulse_before", pulse_in, 1);
        #1 rst_a_n = 1'b0;
        #1;
        chk("t4_rst_pulse_in", pulse_in, 0);
        chk("t4_rst_value_in", value_in, 0);
        chk("t4_rst_level", fifo_level, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_in_ready", in_ready, 1);
        exp_q.delete();
        exp2_q.delete();
        pulse_log.delete();
        repeat (2) @(negedge clk_a);
        rst_a_n = 1'b1;
        repeat (20) @(negedge clk_a);
        chk("t4_no_pulse_after_release", pulse_log.size(), 0);
        do_push(8'h5A);
        stop_push();
        wait_idle();
        chk("t4_pulse_after_push", pulse_log.size(), 1);

`ifndef VALUE_DELIVER_PACER_COALESCE_EN
        // Random traffic on both instances.
        for (int k = 0; k < 400; k++) begin
            @(posedge clk_a);
            #1;
            in_valid  = ($urandom_range(0, 3) == 0);
            in_value  = 8'($urandom);
            in_valid2 = ($urandom_range(0, 1) == 1);
            in_value2 = 8'($urandom);
        end
        @(posedge clk_a);
        #1;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        wait_idle();
        wait_idle2();
`else
        // Overwrite of the youngest entry while full; 8'h00 occupies the pacer.
        wait_idle();
        sb_auto = 1'b0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'hEE);
        do_push(8'h00);
        t = cyc;
        do_push(8'h11);
        do_push(8'h22);
        do_push(8'h33);
        do_push(8'h44);
        do_push(8'hEE);
        stop_push();
        at_cycle(t + 6);
        chk("t6_overwrite_cnt", overwrite_cnt, 1);
        chk("t6_level_full", fifo_level, DEPTH);
        wait_idle();
        sb_auto = 1'b1;
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
